negate_arbiter: RTL and testbench
=================================

NEGATE_ARBITER -- requirements
Module: negate_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; SHALL be 16, matching the shared invert_16bit datapath.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand.
REQ-005 req0_a  input  16  requester 0 operand, two's complement.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has an operand.
REQ-008 req1_a  input  16  requester 1 operand, two's complement.
REQ-009 req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-010 rsp_valid  output  1  response fields valid.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_id  output  1  requester index of this response.
REQ-013 rsp_data  output  16  negated operand (-A).
REQ-014 rsp_ovf  output  1  negation overflowed.

Function
REQ-015 FSM states SHALL be IDLE, CALC and RESP; reset state is IDLE.
REQ-016 A transfer SHALL occur on a cycle where reqN_valid and reqN_ready are both 1.
REQ-017 reqN_ready SHALL be combinational, asserted only in IDLE, and only for the arbitration winner.
REQ-018 At most one reqN_ready SHALL be 1 in any cycle.
REQ-019 Arbitration SHALL be round-robin; pointer prio = requester preferred on a tie; reset value 0.
REQ-020 If only one requester is valid in IDLE, that requester SHALL win regardless of prio.
REQ-021 On a transfer, the operand and winner id SHALL be latched and the FSM SHALL go IDLE->CALC.
REQ-022 On a transfer, prio SHALL be set to the non-winner.
REQ-023 IDLE with no valid request SHALL remain in IDLE.
REQ-024 CALC SHALL last exactly one cycle.
REQ-025 During CALC, the latched operand SHALL be passed through invert_16bit.
REQ-026 During CALC, rsp_data/rsp_ovf SHALL be registered from the invert_16bit outputs and the FSM SHALL go CALC->RESP.
REQ-027 Latency: transfer in cycle N SHALL give rsp_valid=1 in cycle N+2.
REQ-028 rsp_valid SHALL be 1 exactly while in RESP.
REQ-029 rsp_id, rsp_data and rsp_ovf SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-030 RESP with rsp_ready=1 SHALL go RESP->IDLE.
REQ-031 No new transfer SHALL be accepted in the RESP->IDLE cycle; throughput is at most one op per 3 cycles.
REQ-032 rsp_data SHALL equal (~A + 1) modulo 2^16.
REQ-033 rsp_ovf SHALL be 1 iff A = 0x8000; A = 0x8000 SHALL give rsp_data = 0x8000.
REQ-034 A = 0x0000 SHALL give rsp_data = 0x0000 and rsp_ovf = 0.
REQ-035 rsp_ready asserted outside RESP SHALL be ignored.
REQ-036 reqN_valid dropping without a transfer SHALL leave no state change.

Reset
REQ-037 rst_n low SHALL immediately force: state IDLE, prio 0, rsp_valid 0, rsp_id 0, rsp_data 0x0000, rsp_ovf 0, latched operand 0.
REQ-038 rst_n low SHALL immediately force req0_ready = req1_ready = 0.
REQ-039 Reset asserted in CALC or RESP SHALL discard the in-flight op with no response emitted.
REQ-040 After rst_n rises, the first clock edge SHALL behave as IDLE.

Structure
REQ-041 The shared package/header SHALL hold: WIDTH, the FSM state encodings (2 bits), and the requester id constants REQ0 = 0 and REQ1 = 1.
REQ-042 Exactly one sub-module SHALL be used: a single invert_16bit instance (ports A, invA, overflow) shared by both requesters.
REQ-043 No other arithmetic SHALL be duplicated in this block.

Verification
REQ-044 Single op: after reset, req0 sends A=5 and rsp_ready=1 -> req0_ready=1 in cycle N; at N+2 rsp_valid=1, rsp_id=0, rsp_data=0xFFFB, rsp_ovf=0.
REQ-045 Boundaries: req1 sends A=0x8000 -> rsp_data=0x8000, rsp_ovf=1; A=0x7FFF -> rsp_data=0x8001, rsp_ovf=0; A=0 -> rsp_data=0, rsp_ovf=0.
REQ-046 Contention: both requesters held valid for 4 ops, operands req0=-9 and req1=3 -> responses alternate in order id 0,1,0,1 with rsp_data 9, 0xFFFD, 9, 0xFFFD.
REQ-047 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, outputs stable, both reqN_ready=0; rsp_ready=1 -> IDLE the next cycle.
REQ-048 Reset mid-op: rst_n pulsed low during CALC -> all outputs 0 immediately; no rsp_valid afterwards; prio=0, so a simultaneous request pair is granted to req0 first.

Source files
------------

// File: rtl/negate_arbiter_pkg.sv
// Shared definitions for the two-requester negate arbiter: datapath width,
// FSM state encoding and requester id constants.
package negate_arbiter_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/negate_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
// master = requester/consumer side, slave = arbiter side.
interface negate_arbiter_if import negate_arbiter_pkg::*; ();

    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;

    modport master (
        output req0_valid, req0_a, req1_valid, req1_a, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req1_valid, req1_a, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

endinterface

// File: rtl/invert_16bit.sv
// Two's-complement negation of a 16-bit operand; flags the one value
// (0x8000) whose negation is not representable.
module invert_16bit (
    input  logic [15:0] A,
    output logic [15:0] invA,
    output logic        overflow
);

    assign invA     = ~A + 16'd1;
    assign overflow = (A == 16'h8000);

endmodule

// File: rtl/negate_arbiter.sv
// Round-robin arbiter feeding one shared invert_16bit: IDLE grants a
// requester, CALC registers the result, RESP holds it until consumed.
module negate_arbiter #(
    parameter int WIDTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    negate_arbiter_if.slave bus
);
    import negate_arbiter_pkg::*;

    state_t           state;
    logic             prio;
    logic             cur_id;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] inv;
    logic             ovf;
    logic             gnt0, gnt1;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_ovf_q;

    // A lone valid requester wins outright; prio only breaks ties.
    assign gnt0 = rst_n && (state == IDLE) && bus.req0_valid &&
                  (!bus.req1_valid || prio == REQ0);
    assign gnt1 = rst_n && (state == IDLE) && bus.req1_valid &&
                  (!bus.req0_valid || prio == REQ1);

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_ovf    = rsp_ovf_q;

    invert_16bit u_inv (
        .A        (opnd),
        .invA     (inv),
        .overflow (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= REQ0;
            cur_id      <= REQ0;
            opnd        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        opnd   <= gnt1 ? bus.req1_a : bus.req0_a;
                        cur_id <= gnt1 ? REQ1 : REQ0;
                        prio   <= gnt1 ? REQ0 : REQ1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_data_q  <= inv;
                    rsp_ovf_q   <= ovf;
                    rsp_id_q    <= cur_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_negate_arbiter.sv
// Directed and randomized checks of negate_arbiter against a transaction-level
// model: round-robin tie-break, -A modulo 2^16, overflow only for 0x8000.
module tb_negate_arbiter;
    import negate_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    negate_arbiter_if bus ();

    negate_arbiter #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total  = 0;
    int   passed = 0;
    logic m_prio = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] neg_of(input logic [15:0] a);
        return 16'(17'h10000 - {1'b0, a});
    endfunction

    // One complete operation starting in IDLE; hold = RESP cycles with rsp_ready low.
    task automatic op(input bit v0, input logic [15:0] a0, input bit v1, input logic [15:0] a1,
                      input int hold, input bit keep);
        logic        w;
        logic [15:0] a;
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.rsp_ready  = 1'b1;
        #1;
        w = (v0 && v1) ? m_prio : !v0;
        chk("grant_ready0", bus.req0_ready, 32'(v0 && !w));
        chk("grant_ready1", bus.req1_ready, 32'(v1 && w));
        a      = w ? a1 : a0;
        m_prio = !w;
        tick();
        if (!keep) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        #1;
        chk("calc_rsp_valid", bus.rsp_valid, 0);
        chk("calc_readies", {bus.req0_ready, bus.req1_ready}, 0);
        tick();
        for (int i = 0; i <= hold; i++) begin
            bus.rsp_ready = (i == hold);
            #1;
            chk("resp_valid", bus.rsp_valid, 1);
            chk("resp_id", bus.rsp_id, 32'(w));
            chk("resp_data", bus.rsp_data, neg_of(a));
            chk("resp_ovf", bus.rsp_ovf, 32'(a == 16'h8000));
            chk("resp_readies", {bus.req0_ready, bus.req1_ready}, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        bus.req0_valid = 1'b1;
        bus.req0_a     = 16'h1234;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 16'h4321;
        bus.rsp_ready  = 1'b1;
        #2;
        chk("rst_readies", {bus.req0_ready, bus.req1_ready}, 0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_data}, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // single op, then boundaries via req1
        op(1, 16'd5, 0, 16'd0, 0, 0);
        op(0, 16'd0, 1, 16'h8000, 0, 0);
        op(0, 16'd0, 1, 16'h7FFF, 0, 0);
        op(0, 16'd0, 1, 16'h0000, 0, 0);

        // contention: prio is back at 0 here, so ids run 0,1,0,1
        for (int k = 0; k < 4; k++) op(1, 16'hFFF7, 1, 16'd3, 0, 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // backpressure, with both requesters waiting
        op(1, 16'h00AA, 1, 16'h0055, 5, 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("bp_back_idle", bus.rsp_valid, 0);

        // reset during CALC
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_readies", {bus.req0_ready, bus.req1_ready}, 0);
        chk("midrst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_data}, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        rst_n  = 1'b1;
        m_prio = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_no_rsp", bus.rsp_valid, 0);
        end
        op(1, 16'd100, 1, 16'd200, 0, 0);

        // randomized ops with idle gaps and short backpressure
        for (int k = 0; k < 40; k++) begin
            int          sel;
            logic [15:0] ra [2];
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 5))
                    0:       ra[j] = 16'h8000;
                    1:       ra[j] = 16'h7FFF;
                    2:       ra[j] = 16'h0000;
                    3:       ra[j] = 16'hFFFF;
                    default: ra[j] = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
                bus.rsp_ready  = 1'($urandom);
                tick();
                chk("gap_readies", {bus.req0_ready, bus.req1_ready, bus.rsp_valid}, 0);
            end
            sel = $urandom_range(1, 3);
            op(sel[0], ra[0], sel[1], ra[1], $urandom_range(0, 3), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
